// File: rtl/tx_ordering_sequencer.sv
// tx_ordering_sequencer: picks the next TLP among the P / NP / CPL queue heads.
// A candidate head is granted only after the ordering block confirms it may
// pass every other valid head, one pairwise check per clock. Priority rotates
// round-robin after each grant (RR_EN=1) or is fixed P > CPL > NP (RR_EN=0).
// The ordering query fields are registered; the ordering block answers
// combinationally in the same cycle the query is presented.
module tx_ordering_sequencer #(
   parameter int unsigned ID_W   = 16,
   parameter int unsigned TYPE_W = 4,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   // posted queue head
   input  logic              i_p_valid,
   input  logic [TYPE_W-1:0] i_p_type,
   input  logic              i_p_ro,
   input  logic              i_p_ido,
   input  logic [ID_W-1:0]   i_p_id,
   // non-posted queue head
   input  logic              i_np_valid,
   input  logic [TYPE_W-1:0] i_np_type,
   input  logic              i_np_ro,
   input  logic              i_np_ido,
   input  logic [ID_W-1:0]   i_np_id,
   // completion queue head
   input  logic              i_cpl_valid,
   input  logic [TYPE_W-1:0] i_cpl_type,
   input  logic              i_cpl_ro,
   input  logic              i_cpl_ido,
   input  logic [ID_W-1:0]   i_cpl_id,
   input  logic              i_cpl_comp_typ,
   // grant handshake, one-hot {cpl,np,p}
   output logic [2:0]        o_grant,
   output logic              o_grant_valid,
   input  logic              i_grant_ack,
   // ordering query: may second pass first?
   output logic [TYPE_W-1:0] o_first_type,
   output logic              o_first_ro,
   output logic              o_first_ido,
   output logic [ID_W-1:0]   o_first_id,
   output logic [TYPE_W-1:0] o_second_type,
   output logic              o_second_ro,
   output logic              o_second_ido,
   output logic [ID_W-1:0]   o_second_id,
   output logic              o_comp_typ,
   input  logic              i_ordering_result
);

   localparam int unsigned Q_W = 2;
   localparam logic [Q_W-1:0] Q_P   = 2'd0;
   localparam logic [Q_W-1:0] Q_NP  = 2'd1;
   localparam logic [Q_W-1:0] Q_CPL = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_GRANT = 2'd2
   } state_t;

   // queue following q in the P -> NP -> CPL -> P ring
   function automatic logic [Q_W-1:0] next_q(input logic [Q_W-1:0] q);
      return (q == Q_CPL) ? Q_P : Q_W'(q + 2'd1);
   endfunction

   // first valid, non-excluded queue in priority order: {found, queue}
   function automatic logic [Q_W:0] pick(input logic [2:0] valid,
                                         input logic [2:0] excl,
                                         input logic [2:0][Q_W-1:0] ord);
      logic [Q_W:0] res;
      res = '0;
      for (int k = 2; k >= 0; k--) begin
         if (valid[ord[k]] && !excl[ord[k]]) res = {1'b1, ord[k]};
      end
      return res;
   endfunction

   // idx-th valid queue other than cand, in priority order
   function automatic logic [Q_W-1:0] oth_sel(input logic [2:0] valid,
                                              input logic [Q_W-1:0] cand,
                                              input logic [2:0][Q_W-1:0] ord,
                                              input logic idx);
      logic [Q_W-1:0] res;
      logic [1:0]     n;
      res = '0;
      n   = '0;
      for (int k = 0; k < 3; k++) begin
         if (valid[ord[k]] && (ord[k] != cand)) begin
            if (n == 2'(idx)) res = ord[k];
            n = n + 2'd1;
         end
      end
      return res;
   endfunction

   state_t              r_state, w_state_nxt;
   logic [Q_W-1:0]      r_rr_ptr, w_rr_nxt;
   logic [Q_W-1:0]      r_cand, w_cand_nxt;
   logic [Q_W-1:0]      r_first_cand, w_first_cand_nxt;
   logic                r_cmp_idx, w_cmp_idx_nxt;
   logic [1:0]          r_tried_cnt, w_tried_cnt_nxt;
   logic [2:0]          r_tried, w_tried_nxt;
   logic [2:0]          r_snap, w_snap_nxt;

   logic [2:0]          w_valid;
   logic [1:0]          w_valid_cnt;
   logic [2:0][Q_W-1:0] w_ord;
   logic [Q_W:0]        w_start;
   logic [Q_W:0]        w_retry;
   logic [2:0]          w_tried_upd;
   logic                w_last;
   logic [Q_W-1:0]      w_fq;

   logic [2:0]          w_grant_nxt;
   logic                w_grant_valid_nxt;
   logic [TYPE_W-1:0]   w_first_type_nxt, w_second_type_nxt;
   logic                w_first_ro_nxt, w_second_ro_nxt;
   logic                w_first_ido_nxt, w_second_ido_nxt;
   logic [ID_W-1:0]     w_first_id_nxt, w_second_id_nxt;
   logic                w_comp_typ_nxt;

   assign w_valid     = {i_cpl_valid, i_np_valid, i_p_valid};
   assign w_valid_cnt = 2'(i_p_valid) + 2'(i_np_valid) + 2'(i_cpl_valid);

   // priority order of the three queues for this decision
   always_comb begin
      if (RR_EN) begin
         w_ord[0] = r_rr_ptr;
         w_ord[1] = next_q(r_rr_ptr);
         w_ord[2] = next_q(next_q(r_rr_ptr));
      end else begin
         w_ord[0] = Q_P;
         w_ord[1] = Q_CPL;
         w_ord[2] = Q_NP;
      end
   end

   assign w_start     = pick(w_valid, 3'b000, w_ord);
   assign w_tried_upd = r_tried | (3'b001 << r_cand);
   assign w_retry     = pick(w_valid, w_tried_upd, w_ord);
   assign w_last      = ((2'(r_cmp_idx) + 2'd1) == (w_valid_cnt - 2'd1));

   // state register and decision bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= Q_P;
         r_cand       <= Q_P;
         r_first_cand <= Q_P;
         r_cmp_idx    <= 1'b0;
         r_tried_cnt  <= 2'd0;
         r_tried      <= 3'b000;
         r_snap       <= 3'b000;
      end else begin
         r_state      <= w_state_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_cand       <= w_cand_nxt;
         r_first_cand <= w_first_cand_nxt;
         r_cmp_idx    <= w_cmp_idx_nxt;
         r_tried_cnt  <= w_tried_cnt_nxt;
         r_tried      <= w_tried_nxt;
         r_snap       <= w_snap_nxt;
      end
   end

   // next-state: candidate selection, pairwise walk, blocking and fallback
   always_comb begin
      w_state_nxt      = r_state;
      w_rr_nxt         = r_rr_ptr;
      w_cand_nxt       = r_cand;
      w_first_cand_nxt = r_first_cand;
      w_cmp_idx_nxt    = r_cmp_idx;
      w_tried_cnt_nxt  = r_tried_cnt;
      w_tried_nxt      = r_tried;
      w_snap_nxt       = r_snap;
      case (r_state)
         S_IDLE: begin
            if (w_start[Q_W]) begin
               w_cand_nxt       = w_start[Q_W-1:0];
               w_first_cand_nxt = w_start[Q_W-1:0];
               w_cmp_idx_nxt    = 1'b0;
               w_tried_cnt_nxt  = 2'd1;
               w_tried_nxt      = 3'b000;
               w_snap_nxt       = w_valid;
               w_state_nxt      = (w_valid_cnt == 2'd1) ? S_GRANT : S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_valid != r_snap) begin
               // head set changed under us: drop the decision
               w_state_nxt = S_IDLE;
            end else if (i_ordering_result) begin
               if (w_last) w_state_nxt   = S_GRANT;
               else        w_cmp_idx_nxt = 1'b1;
            end else begin
               w_tried_nxt = w_tried_upd;
               if ((r_tried_cnt == w_valid_cnt) || !w_retry[Q_W]) begin
                  // every candidate blocked: break the deadlock
                  w_cand_nxt  = i_p_valid ? Q_P : r_first_cand;
                  w_state_nxt = S_GRANT;
               end else begin
                  w_cand_nxt      = w_retry[Q_W-1:0];
                  w_cmp_idx_nxt   = 1'b0;
                  w_tried_cnt_nxt = r_tried_cnt + 2'd1;
               end
            end
         end
         S_GRANT: begin
            if (i_grant_ack) begin
               w_state_nxt = S_IDLE;
               if (RR_EN) w_rr_nxt = next_q(r_cand);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // output decode for the upcoming state
   always_comb begin
      w_grant_nxt       = 3'b000;
      w_grant_valid_nxt = 1'b0;
      w_first_type_nxt  = '0;
      w_first_ro_nxt    = 1'b0;
      w_first_ido_nxt   = 1'b0;
      w_first_id_nxt    = '0;
      w_second_type_nxt = '0;
      w_second_ro_nxt   = 1'b0;
      w_second_ido_nxt  = 1'b0;
      w_second_id_nxt   = '0;
      w_comp_typ_nxt    = 1'b0;
      w_fq              = oth_sel(w_valid, w_cand_nxt, w_ord, w_cmp_idx_nxt);
      if (w_state_nxt == S_CHECK) begin
         case (w_fq)
            Q_P: begin
               w_first_type_nxt = i_p_type;
               w_first_ro_nxt   = i_p_ro;
               w_first_ido_nxt  = i_p_ido;
               w_first_id_nxt   = i_p_id;
            end
            Q_NP: begin
               w_first_type_nxt = i_np_type;
               w_first_ro_nxt   = i_np_ro;
               w_first_ido_nxt  = i_np_ido;
               w_first_id_nxt   = i_np_id;
            end
            default: begin
               w_first_type_nxt = i_cpl_type;
               w_first_ro_nxt   = i_cpl_ro;
               w_first_ido_nxt  = i_cpl_ido;
               w_first_id_nxt   = i_cpl_id;
            end
         endcase
         case (w_cand_nxt)
            Q_P: begin
               w_second_type_nxt = i_p_type;
               w_second_ro_nxt   = i_p_ro;
               w_second_ido_nxt  = i_p_ido;
               w_second_id_nxt   = i_p_id;
            end
            Q_NP: begin
               w_second_type_nxt = i_np_type;
               w_second_ro_nxt   = i_np_ro;
               w_second_ido_nxt  = i_np_ido;
               w_second_id_nxt   = i_np_id;
            end
            default: begin
               w_second_type_nxt = i_cpl_type;
               w_second_ro_nxt   = i_cpl_ro;
               w_second_ido_nxt  = i_cpl_ido;
               w_second_id_nxt   = i_cpl_id;
            end
         endcase
         if ((w_fq == Q_CPL) || (w_cand_nxt == Q_CPL)) w_comp_typ_nxt = i_cpl_comp_typ;
      end
      if (w_state_nxt == S_GRANT) begin
         w_grant_nxt       = 3'b001 << w_cand_nxt;
         w_grant_valid_nxt = 1'b1;
      end
   end

   // registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         o_grant       <= 3'b000;
         o_grant_valid <= 1'b0;
         o_first_type  <= '0;
         o_first_ro    <= 1'b0;
         o_first_ido   <= 1'b0;
         o_first_id    <= '0;
         o_second_type <= '0;
         o_second_ro   <= 1'b0;
         o_second_ido  <= 1'b0;
         o_second_id   <= '0;
         o_comp_typ    <= 1'b0;
      end else begin
         o_grant       <= w_grant_nxt;
         o_grant_valid <= w_grant_valid_nxt;
         o_first_type  <= w_first_type_nxt;
         o_first_ro    <= w_first_ro_nxt;
         o_first_ido   <= w_first_ido_nxt;
         o_first_id    <= w_first_id_nxt;
         o_second_type <= w_second_type_nxt;
         o_second_ro   <= w_second_ro_nxt;
         o_second_ido  <= w_second_ido_nxt;
         o_second_id   <= w_second_id_nxt;
         o_comp_typ    <= w_comp_typ_nxt;
      end
   end

endmodule

// File: tb/tb_tx_ordering_sequencer.sv
// Bench for tx_ordering_sequencer: directed head patterns, an ordering-block
// model answering from a block table, and a grant scoreboard.
module tb_tx_ordering_sequencer;

   localparam int unsigned ID_W   = 16;
   localparam int unsigned TYPE_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              p_valid, np_valid, cpl_valid;
   logic [TYPE_W-1:0] p_type, np_type, cpl_type;
   logic              p_ro, np_ro, cpl_ro;
   logic              p_ido, np_ido, cpl_ido;
   logic [ID_W-1:0]   p_id, np_id, cpl_id;
   logic              cpl_comp_typ;
   logic [2:0]        grant;
   logic              grant_valid;
   logic              grant_ack;
   logic [TYPE_W-1:0] first_type, second_type;
   logic              first_ro, second_ro, first_ido, second_ido;
   logic [ID_W-1:0]   first_id, second_id;
   logic              comp_typ;
   logic              ord_res;

   int                n_tests = 0;
   int                n_fail  = 0;
   logic [2:0]        sb_q[$];
   logic              seen = 1'b0;

   // ordering model: 0 all pass, 1 all blocked, 2 blocked pairs from blk[first*3+second]
   int                mode = 0;
   logic [8:0]        blk  = '0;
   int                fq_m, sq_m;

   // captured query fields during the first decision cycle
   logic [ID_W-1:0]   s_first_id, s_second_id;
   logic [TYPE_W-1:0] s_first_type, s_second_type;
   logic              s_first_ro, s_second_ro, s_first_ido, s_comp;

   always #5 clk = ~clk;

   tx_ordering_sequencer #(.ID_W(ID_W), .TYPE_W(TYPE_W), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .i_p_valid(p_valid), .i_p_type(p_type), .i_p_ro(p_ro), .i_p_ido(p_ido), .i_p_id(p_id),
      .i_np_valid(np_valid), .i_np_type(np_type), .i_np_ro(np_ro), .i_np_ido(np_ido), .i_np_id(np_id),
      .i_cpl_valid(cpl_valid), .i_cpl_type(cpl_type), .i_cpl_ro(cpl_ro), .i_cpl_ido(cpl_ido),
      .i_cpl_id(cpl_id), .i_cpl_comp_typ(cpl_comp_typ),
      .o_grant(grant), .o_grant_valid(grant_valid), .i_grant_ack(grant_ack),
      .o_first_type(first_type), .o_first_ro(first_ro), .o_first_ido(first_ido), .o_first_id(first_id),
      .o_second_type(second_type), .o_second_ro(second_ro), .o_second_ido(second_ido),
      .o_second_id(second_id), .o_comp_typ(comp_typ), .i_ordering_result(ord_res)
   );

   function automatic int id2q(input logic [ID_W-1:0] id);
      if (id == 16'h1111) return 0;
      if (id == 16'h2222) return 1;
      if (id == 16'hABCD) return 2;
      return 3;
   endfunction

   always_comb begin
      fq_m    = id2q(first_id);
      sq_m    = id2q(second_id);
      ord_res = 1'b1;
      if (mode == 1) ord_res = 1'b0;
      else if (mode == 2 && fq_m < 3 && sq_m < 3) ord_res = !blk[fq_m*3 + sq_m];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every new grant must match the oldest expected one
   always @(negedge clk) begin
      if (grant_valid && !seen) begin
         seen = 1'b1;
         if (sb_q.size() == 0) chk("unexpected_grant", 32'(grant), 32'h0);
         else                  chk("grant", 32'(grant), 32'(sb_q.pop_front()));
      end else if (!grant_valid) begin
         seen = 1'b0;
      end
   end

   // present heads, wait for the grant, check latency and hold, then acknowledge
   task automatic run_case(input string name, input logic [2:0] vmask,
                           input logic [2:0] exp_grant, input int exp_lat);
      int lat;
      bit got;
      sb_q.push_back(exp_grant);
      @(posedge clk); #1;
      p_valid = vmask[0]; np_valid = vmask[1]; cpl_valid = vmask[2];
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (lat == 1) begin
            s_first_id = first_id; s_second_id = second_id;
            s_first_type = first_type; s_second_type = second_type;
            s_first_ro = first_ro; s_second_ro = second_ro;
            s_first_ido = first_ido; s_comp = comp_typ;
         end
         if (grant_valid) got = 1'b1;
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      @(posedge clk); @(negedge clk);
      chk({name, "_hold"}, {28'h0, grant_valid, grant}, {28'h0, 1'b1, exp_grant});
      @(posedge clk); #1;
      grant_ack = 1'b1;
      p_valid = 1'b0; np_valid = 1'b0; cpl_valid = 1'b0;
      @(posedge clk); #1;
      grant_ack = 1'b0;
      @(negedge clk);
      chk({name, "_release"}, {28'h0, grant_valid, grant}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; grant_ack = 1'b0; cpl_comp_typ = 1'b0;
      p_valid = 1'b0;   p_type = 4'h3;   p_ro = 1'b0;   p_ido = 1'b1;   p_id = 16'h1111;
      np_valid = 1'b0;  np_type = 4'h5;  np_ro = 1'b0;  np_ido = 1'b0;  np_id = 16'h2222;
      cpl_valid = 1'b0; cpl_type = 4'hA; cpl_ro = 1'b0; cpl_ido = 1'b0; cpl_id = 16'hABCD;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", {28'h0, grant_valid, grant}, 32'h0);
      chk("rst_ord_ids", {first_id, second_id}, 32'h0);
      chk("rst_ord_misc", {22'h0, first_type, second_type, first_ro, second_ro}, 32'h0);
      chk("rst_comp_typ", 32'(comp_typ), 32'h0);
      rst = 1'b0;

      // stray ack with nothing granted
      grant_ack = 1'b1;
      @(negedge clk);
      grant_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack", {28'h0, grant_valid, grant}, 32'h0);

      // p,np from rr=P, all pass: one check, P wins
      mode = 0;
      run_case("p_np_pass", 3'b011, 3'b001, 2);
      chk("p_np_first_id", 32'(s_first_id), 32'h2222);
      chk("p_np_second_id", 32'(s_second_id), 32'h1111);

      // rr=NP, NP blocked behind P, then P passes NP
      mode = 2; blk = 9'b0_0000_0010;
      run_case("np_blocked", 3'b011, 3'b001, 3);
      chk("np_blocked_first_check", {s_first_id, s_second_id}, 32'h1111_2222);

      // single NP head (rr=NP)
      mode = 0;
      run_case("np_only", 3'b010, 3'b010, 1);

      // rr=CPL: CPL candidate checked against P
      cpl_comp_typ = 1'b1; cpl_ro = 1'b1;
      run_case("cpl_vs_p", 3'b101, 3'b100, 2);
      chk("cpl_vs_p_ids", {s_first_id, s_second_id}, 32'h1111_ABCD);
      chk("cpl_vs_p_types", {24'h0, s_first_type, s_second_type}, 32'h3A);
      chk("cpl_vs_p_attr", {29'h0, s_first_ro, s_second_ro, s_first_ido}, 32'h3);
      chk("cpl_vs_p_comp_typ", 32'(s_comp), 32'h1);
      cpl_comp_typ = 1'b0; cpl_ro = 1'b0;

      // rr=P, everything blocked: fallback to P after three checks
      mode = 1;
      run_case("all_blocked", 3'b111, 3'b001, 4);

      // rr=NP, each candidate passes one head then blocks: six checks, fallback P
      mode = 2; blk = 9'b0_0100_0110;
      run_case("worst_case", 3'b111, 3'b001, 7);

      // reset mid-decision, then abort on a head change
      mode = 0;
      @(posedge clk); #1;
      p_valid = 1'b1; np_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_second_id", 32'(second_id), 32'h2222);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_check", {grant_valid, grant, 12'h0, second_id}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_ids", {first_id, second_id}, 32'h2222_1111);
      np_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_idle", {grant_valid, grant, 12'h0, second_id}, 32'h0);
      p_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_grant", {28'h0, grant_valid, grant}, 32'h0);

      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
